// File: rtl/divisor_pkg.sv
// divisor_pkg: shared widths and FSM encoding
// for the sequential divider and its bench.
package divisor_pkg;

  localparam int DdLen = 15;
  localparam int DvLen = 7;
  localparam int QLen  = 15;

  typedef enum logic [1:0] {
    LISTO      = 2'd0,
    DIVIDIENDO = 2'd1,
    ESPERA     = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_ruta_datos.sv
// divisor_ruta_datos: restoring shift-subtract
// datapath, one quotient bit per step, MSB first.
module divisor_ruta_datos
  import divisor_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_cargar,
  input  logic           i_paso,
  input  logic [DdLen:0] i_dividendo,
  input  logic [DvLen:0] i_divisor,
  output logic [QLen:0]  o_cociente,
  output logic [DvLen:0] o_residuo,
  output logic           o_div_cero,
  output logic           o_ultimo
);

  logic [DdLen:0] r_dd;
  logic [DvLen:0] r_dv;
  logic [DvLen:0] r_rem;
  logic [3:0]     r_cnt;

  logic [DvLen+1:0] w_rem_desp;
  logic [DvLen:0]   w_resta;
  logic             w_bit;
  logic [DvLen:0]   w_rem_sig;
  logic [DdLen:0]   w_dd_sig;

  assign w_rem_desp = {r_rem, r_dd[DdLen]};
  assign w_resta    = w_rem_desp[DvLen:0] - r_dv;
  assign w_bit      = w_rem_desp[DvLen+1] |
                      (w_rem_desp[DvLen:0] >= r_dv);
  assign w_rem_sig  = w_bit ? w_resta
                            : w_rem_desp[DvLen:0];
  assign w_dd_sig   = {r_dd[DdLen-1:0], w_bit};

  assign o_ultimo   = (r_cnt == 4'hF);
  assign o_div_cero = (r_dv == '0);
  assign o_cociente = o_div_cero ? '1 : w_dd_sig;
  assign o_residuo  = o_div_cero ? '0 : w_rem_sig;

  // operand latch, then one shift-subtract step per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dd  <= '0;
      r_dv  <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (i_cargar) begin
      r_dd  <= i_dividendo;
      r_dv  <= i_divisor;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (i_paso) begin
      r_dd  <= w_dd_sig;
      r_rem <= w_rem_sig;
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: 16-cycle unsigned divider
// with a four-phase inicie/termino handshake.
module divisor_secuencial
  import divisor_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           inicie,
  input  logic [DdLen:0] dividendo,
  input  logic [DvLen:0] divisor,
  output logic           termino,
  output logic [QLen:0]  cociente,
  output logic [DvLen:0] residuo,
  output logic           div_cero
);

  estado_t r_estado;
  estado_t w_estado_sig;

  logic           r_termino;
  logic [QLen:0]  r_cociente;
  logic [DvLen:0] r_residuo;
  logic           r_div_cero;

  logic           w_cargar;
  logic           w_paso;
  logic           w_ultimo;
  logic           w_fin;
  logic [QLen:0]  w_cociente;
  logic [DvLen:0] w_residuo;
  logic           w_div_cero;

  assign w_cargar = (r_estado == LISTO) & inicie;
  assign w_paso   = (r_estado == DIVIDIENDO);
  assign w_fin    = w_paso & w_ultimo;

  divisor_ruta_datos u_ruta (
    .clk         (clk),
    .rst         (reset),
    .i_cargar    (w_cargar),
    .i_paso      (w_paso),
    .i_dividendo (dividendo),
    .i_divisor   (divisor),
    .o_cociente  (w_cociente),
    .o_residuo   (w_residuo),
    .o_div_cero  (w_div_cero),
    .o_ultimo    (w_ultimo)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= LISTO;
    else       r_estado <= w_estado_sig;
  end

  // next state: start on inicie, finish after 16 steps,
  // wait for inicie low before accepting a new request
  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      LISTO:      if (inicie)   w_estado_sig = DIVIDIENDO;
      DIVIDIENDO: if (w_ultimo) w_estado_sig = ESPERA;
      ESPERA:     if (!inicie)  w_estado_sig = LISTO;
      default:                  w_estado_sig = LISTO;
    endcase
  end

  // registered outputs; result loaded on the last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_termino  <= 1'b1;
      r_cociente <= '0;
      r_residuo  <= '0;
      r_div_cero <= 1'b0;
    end else if (w_fin) begin
      r_termino  <= 1'b1;
      r_cociente <= w_cociente;
      r_residuo  <= w_residuo;
      r_div_cero <= w_div_cero;
    end else if (w_cargar) begin
      r_termino  <= 1'b0;
    end
  end

  assign termino  = r_termino;
  assign cociente = r_cociente;
  assign residuo  = r_residuo;
  assign div_cero = r_div_cero;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: directed bench with a
// result scoreboard for the sequential divider.
module tb_divisor_secuencial;
  import divisor_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           inicie;
  logic [DdLen:0] dividendo;
  logic [DvLen:0] divisor;
  logic           termino;
  logic [QLen:0]  cociente;
  logic [DvLen:0] residuo;
  logic           div_cero;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } res_t;

  res_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  divisor_secuencial dut (
    .clk       (clk),
    .reset     (reset),
    .inicie    (inicie),
    .dividendo (dividendo),
    .divisor   (divisor),
    .termino   (termino),
    .cociente  (cociente),
    .residuo   (residuo),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_div(input logic [15:0] dd,
                           input logic [7:0] dv);
    res_t e;
    @(negedge clk);
    dividendo = dd;
    divisor   = dv;
    inicie    = 1'b1;
    if (dv == 8'd0) begin
      e.q = 16'hFFFF; e.r = 8'h00; e.z = 1'b1;
    end else begin
      e.q = dd / {8'd0, dv};
      e.r = 8'(dd % {8'd0, dv});
      e.z = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    t0 = cyc;
    chk("busy_after_start", {31'd0, termino}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    res_t e;
    int n;
    n = 0;
    while (termino !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, cyc - t0, 32'd16);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, {16'd0, cociente}, {16'd0, e.q});
      chk({tag, "_r"}, {24'd0, residuo}, {24'd0, e.r});
      chk({tag, "_z"}, {31'd0, div_cero}, {31'd0, e.z});
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    inicie = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_termino"}, {31'd0, termino}, 32'd1);
    chk({tag, "_q"}, {16'd0, cociente}, 32'd0);
    chk({tag, "_r"}, {24'd0, residuo}, 32'd0);
    chk({tag, "_z"}, {31'd0, div_cero}, 32'd0);
  endtask

  initial begin
    logic [15:0] hq;
    logic [7:0]  hr;
    logic [15:0] rd;
    logic [7:0]  rv;
    reset     = 1'b1;
    inicie    = 1'b0;
    dividendo = '0;
    divisor   = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    start_div(16'h0064, 8'h07);
    wait_done("d100_7");
    chk("d100_7_q_const", {16'd0, cociente}, 32'h000E);
    chk("d100_7_r_const", {24'd0, residuo}, 32'h02);
    release_req();

    start_div(16'hFFFF, 8'h01);
    wait_done("dffff_1");
    release_req();

    start_div(16'h0005, 8'h09);
    wait_done("d5_9");
    release_req();

    start_div(16'h1234, 8'h00);
    wait_done("dzero");
    release_req();

    start_div(16'hFFFF, 8'hFF);
    wait_done("dffff_ff");
    hq = 16'h0101;
    hr = 8'h00;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("hold_termino", {31'd0, termino}, 32'd1);
    end
    chk("hold_q", {16'd0, cociente}, {16'd0, hq});
    chk("hold_r", {24'd0, residuo}, {24'd0, hr});
    @(negedge clk);
    inicie = 1'b0;
    @(posedge clk);
    #1;
    chk("listo_q", {16'd0, cociente}, {16'd0, hq});
    chk("listo_termino", {31'd0, termino}, 32'd1);
    start_div(16'h00C8, 8'h0B);
    wait_done("restart");
    release_req();

    start_div(16'h0064, 8'h07);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    chk_zero("abort");
    inicie = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("abort_idle");
    start_div(16'h0064, 8'h07);
    wait_done("after_abort");
    release_req();

    start_div(16'hABCD, 8'h13);
    repeat (3) @(negedge clk);
    dividendo = 16'h0000;
    divisor   = 8'hFF;
    wait_done("midchange");
    release_req();

    for (int i = 0; i < 6; i++) begin
      rd = 16'($urandom);
      rv = 8'($urandom_range(1, 255));
      start_div(rd, rv);
      wait_done("rand");
      release_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port inicie, input, 1 bit: division request / result-taken handshake from the requester.
REQ-004 SHALL have port dividendo, input, `DdLen+1 (16) bits: unsigned dividend.
REQ-005 SHALL have port divisor, input, `DvLen+1 (8) bits: unsigned divisor.
REQ-006 SHALL have port termino, output, 1 bit: 1 = idle or result valid; 0 = dividing.
REQ-007 SHALL have port cociente, output, `QLen+1 (16) bits: unsigned quotient.
REQ-008 SHALL have port residuo, output, `DvLen+1 (8) bits: unsigned remainder.
REQ-009 SHALL have port div_cero, output, 1 bit: last division had divisor == 0.
REQ-010 SHALL use constants DdLen = 15, DvLen = 7, QLen = 15 (MSB indices).

Function
REQ-011 SHALL implement an FSM with states LISTO (termino=1), DIVIDIENDO (termino=0), and ESPERA (termino=1, result held).
REQ-012 In LISTO, SHALL sample inicie=1 at edge E0, latch dividendo and divisor, clear the iteration counter, and enter DIVIDIENDO with termino=0 after E0.
REQ-013 In DIVIDIENDO, SHALL perform one restoring shift-subtract step per cycle, quotient MSB first, using a 9-bit partial remainder.
REQ-014 SHALL complete exactly 16 steps, on edges E0+1 through E0+16; at E0+16 SHALL load cociente/residuo/div_cero, enter ESPERA, and drive termino=1.
REQ-015 termino SHALL be low for exactly 16 clock cycles per division, regardless of operand values.
REQ-016 In ESPERA, SHALL hold outputs stable and remain while inicie=1; inicie=0 SHALL cause a move to LISTO.
REQ-017 Outputs SHALL stay unchanged in LISTO until the next result is loaded.
REQ-018 inicie held at 1 through ESPERA SHALL NOT start a second division; a new division requires inicie 1->0->1 (four-phase handshake).
REQ-019 Changes on dividendo/divisor after E0 SHALL be ignored until the next start.
REQ-020 inicie changes during DIVIDIENDO SHALL be ignored.
REQ-021 On divisor == 0, SHALL still take 16 cycles, then output cociente=16'hFFFF, residuo=8'h00, div_cero=1.
REQ-022 For divisor != 0, SHALL satisfy dividendo == cociente*divisor + residuo with residuo < divisor, and div_cero=0.
REQ-023 termino, cociente, residuo, and div_cero SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-024 reset=1 SHALL immediately force LISTO, termino=1, cociente=0, residuo=0, div_cero=0, and clear the counter and working registers.
REQ-025 reset asserted during DIVIDIENDO SHALL abort the division; no partial result SHALL appear.
REQ-026 After reset deasserts, the first start SHALL require inicie=1 sampled in LISTO.

Structure
REQ-027 DdLen, DvLen, QLen, and state encodings SHALL live in the shared divider defines header used by the bench.
REQ-028 The datapath (operand, partial-remainder, and quotient shift registers, plus the 4-bit step counter) SHALL be one sub-module, divisor_ruta_datos; the FSM SHALL stay in divisor_secuencial.

Verification
REQ-029 Scenario: 0x0064 / 0x07 -> after 16 cycles termino=1, cociente=0x000E, residuo=0x02, div_cero=0.
REQ-030 Scenario: 0xFFFF / 0x01 -> cociente=0xFFFF, residuo=0x00; 0x0005 / 0x09 -> cociente=0x0000, residuo=0x05.
REQ-031 Scenario: 0x1234 / 0x00 -> 16 cycles later cociente=0xFFFF, residuo=0x00, div_cero=1.
REQ-032 Scenario: inicie held high 20 cycles after termino rises -> termino stays 1, outputs unchanged, no restart; drop then raise inicie -> new division starts.
REQ-033 Scenario: reset pulsed at step 8 of 0x0064 / 0x07 -> termino=1 and cociente=0 immediately; next request 0x0064 / 0x07 -> correct result.
REQ-034 Scenario: dividendo/divisor changed to 0x0000/0xFF mid-division -> result still matches the latched operands.
